flag_unit: RTL and testbench

- Flag register and flag producer for the 16-bit pipelined core; the branch-condition logic is its consumer.
- Computes Z/V/N from the EX-stage ALU result under per-opcode write masks and holds them across stalls, flushes and halt.
- Supplies registered and forwarded flag vectors to branch resolution in ID.
- Raises a branch hazard when a flag producer is still in flight.

---
 rtl/flag_unit.sv | 133 +++++++++++++
 tb/tb_flag_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/flag_unit.sv
`default_nettype none
// ============================================================================
// Module   : flag_unit
// Purpose  : Flag register and flag producer for the 16-bit pipelined core.
//            Computes {Z,V,N} from the EX-stage ALU result under a per-opcode
//            write mask, holds them across stalls/flushes/halt, supplies a
//            registered and a forwarded flag vector to ID branch resolution,
//            and raises a branch hazard when forwarding is not built in.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Build option:
//   FLAG_FWD_EN  defined   -> flags_fwd forwards the in-flight EX update,
//                             br_hazard tied 0.
//                undefined -> flags_fwd = flags, br_hazard stalls an ID
//                             branch while a flag producer sits in EX.
// ----------------------------------------------------------------------------
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   ex_valid     in   EX holds a real instruction
//   ex_opcode    in   [3:0] EX opcode
//   alu_result   in   [DATA_W-1:0] EX ALU result
//   alu_ovfl     in   signed overflow from EX ADD/SUB
//   stall        in   pipeline stall (EX instruction repeats)
//   flush        in   squash EX instruction
//   id_is_branch in   ID holds a conditional branch
//   flags        out  [2:0] registered {Z,V,N}
//   flags_fwd    out  [2:0] flag vector ID branch uses this cycle
//   br_hazard    out  ID branch must stall one cycle
//   halted       out  HLT retired through EX, flags frozen
//   ovf_count    out  [OVF_CNT_W-1:0] saturating count of committed V=1
// ============================================================================
module flag_unit #(
    parameter int DATA_W    = 16,
    parameter int OVF_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ex_valid,
    input  logic [3:0]           ex_opcode,
    input  logic [DATA_W-1:0]    alu_result,
    input  logic                 alu_ovfl,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 id_is_branch,
    output logic [2:0]           flags,
    output logic [2:0]           flags_fwd,
    output logic                 br_hazard,
    output logic                 halted,
    output logic [OVF_CNT_W-1:0] ovf_count
);

    localparam logic [3:0] c_OP_ADD = 4'b0000;
    localparam logic [3:0] c_OP_SUB = 4'b0001;
    localparam logic [3:0] c_OP_XOR = 4'b0010;
    localparam logic [3:0] c_OP_SLL = 4'b0100;
    localparam logic [3:0] c_OP_SRA = 4'b0101;
    localparam logic [3:0] c_OP_ROR = 4'b0110;
    localparam logic [3:0] c_OP_HLT = 4'b1111;

    // Bit order of every flag vector: [2]=Z, [1]=V, [0]=N
    localparam logic [2:0] c_MASK_ZVN  = 3'b111;
    localparam logic [2:0] c_MASK_Z    = 3'b100;
    localparam logic [2:0] c_MASK_NONE = 3'b000;

    logic [2:0]           r_flags;
    logic                 r_halted;
    logic [OVF_CNT_W-1:0] r_ovf_count;

    logic [2:0]           w_mask;
    logic [2:0]           w_new;
    logic [2:0]           w_merged;
    logic                 w_issue;
    logic                 w_commit;
    logic                 w_halt_req;
    logic                 w_ovf_event;

    always_comb begin
        w_mask = c_MASK_NONE;
        case (ex_opcode)
            c_OP_ADD, c_OP_SUB:           w_mask = c_MASK_ZVN;
            c_OP_XOR, c_OP_SLL,
            c_OP_SRA, c_OP_ROR:           w_mask = c_MASK_Z;
            default:                      w_mask = c_MASK_NONE;
        endcase
    end

    assign w_new    = {(alu_result == '0), alu_ovfl, alu_result[DATA_W-1]};
    assign w_merged = (w_new & w_mask) | (r_flags & ~w_mask);

    // flush dominates stall: either one blocks the commit
    assign w_issue     = ex_valid & ~stall & ~flush;
    assign w_commit    = w_issue & ~r_halted & (w_mask != c_MASK_NONE);
    assign w_halt_req  = w_issue & (ex_opcode == c_OP_HLT);
    // V is written only by ADD/SUB, so a committed V=1 means the mask has V set
    assign w_ovf_event = w_commit & w_mask[1] & alu_ovfl;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flags     <= 3'b000;
            r_halted    <= 1'b0;
            r_ovf_count <= '0;
        end else begin
            if (w_commit) begin
                r_flags <= w_merged;
            end
            if (w_halt_req) begin
                r_halted <= 1'b1;
            end
            if (w_ovf_event && (r_ovf_count != {OVF_CNT_W{1'b1}})) begin
                r_ovf_count <= r_ovf_count + 1'b1;
            end
        end
    end

`ifdef FLAG_FWD_EN
    // The branch sees the value that will be committed on this edge
    assign flags_fwd = w_commit ? w_merged : r_flags;
    assign br_hazard = 1'b0;
`else
    // No bypass: hold the branch while a producer occupies EX. stall is
    // deliberately not in the term; a stalled producer still has to land.
    assign flags_fwd = r_flags;
    assign br_hazard = id_is_branch & ex_valid & ~flush & ~r_halted
                       & (w_mask != c_MASK_NONE);
`endif

    assign flags     = r_flags;
    assign halted    = r_halted;
    assign ovf_count = r_ovf_count;

endmodule
`default_nettype wire

// File: tb/tb_flag_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_flag_unit
// Purpose  : Self-checking bench for flag_unit: directed vector table,
//            overflow-counter saturation run, and randomized traffic against
//            a behavioural flag model.
// Revision : 1.0  initial release
// ============================================================================
module tb_flag_unit;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic [3:0]  ex_opcode;
    logic [15:0] alu_result;
    logic        alu_ovfl;
    logic        stall;
    logic        flush;
    logic        id_is_branch;
    logic [2:0]  flags;
    logic [2:0]  flags_fwd;
    logic        br_hazard;
    logic        halted;
    logic [7:0]  ovf_count;

    int checks;
    int errors;

    flag_unit #(.DATA_W(16), .OVF_CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid     (ex_valid),
        .ex_opcode    (ex_opcode),
        .alu_result   (alu_result),
        .alu_ovfl     (alu_ovfl),
        .stall        (stall),
        .flush        (flush),
        .id_is_branch (id_is_branch),
        .flags        (flags),
        .flags_fwd    (flags_fwd),
        .br_hazard    (br_hazard),
        .halted       (halted),
        .ovf_count    (ovf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model: individual flag bits, a halt bit, an integer count
    // ------------------------------------------------------------------
    bit m_z, m_v, m_n, m_halt;
    int m_ovf;

    function automatic bit writes_z(input logic [3:0] op);
        return (op == 4'd0) || (op == 4'd1) || (op == 4'd2) ||
               (op == 4'd4) || (op == 4'd5) || (op == 4'd6);
    endfunction

    function automatic bit writes_vn(input logic [3:0] op);
        return (op == 4'd0) || (op == 4'd1);
    endfunction

    function automatic bit m_commits();
        return ex_valid && !stall && !flush && !m_halt && writes_z(ex_opcode);
    endfunction

    function automatic logic [2:0] m_flags();
        return {m_z, m_v, m_n};
    endfunction

    function automatic logic [2:0] m_next();
        bit z, v, n;
        z = m_z; v = m_v; n = m_n;
        if (m_commits()) begin
            z = (alu_result == 16'h0000);
            if (writes_vn(ex_opcode)) begin
                v = alu_ovfl;
                n = alu_result[15];
            end
        end
        return {z, v, n};
    endfunction

    function automatic logic [2:0] m_fwd();
`ifdef FLAG_FWD_EN
        return m_next();
`else
        return m_flags();
`endif
    endfunction

    function automatic logic m_haz();
`ifdef FLAG_FWD_EN
        return 1'b0;
`else
        return id_is_branch && ex_valid && !flush && !m_halt && writes_z(ex_opcode);
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [3:0] op,
                         input logic [15:0] res, input logic ov, input logic st,
                         input logic fl, input logic br);
        rst = r; ex_valid = v; ex_opcode = op; alu_result = res;
        alu_ovfl = ov; stall = st; flush = fl; id_is_branch = br;
    endtask

    // Advance one edge; the model absorbs the inputs held across it
    task automatic tick();
        logic [2:0] nx;
        @(posedge clk);
        nx = m_next();
        if (rst) begin
            m_z = 0; m_v = 0; m_n = 0; m_halt = 0; m_ovf = 0;
        end else begin
            if (m_commits() && writes_vn(ex_opcode) && alu_ovfl)
                m_ovf = (m_ovf >= 255) ? 255 : m_ovf + 1;
            {m_z, m_v, m_n} = nx;
            if (ex_valid && !stall && !flush && ex_opcode == 4'hF) m_halt = 1;
        end
        #1;
    endtask

    // ------------------------------------------------------------------
    // Directed table: expected values are what is seen during the cycle the
    // inputs are applied (registered outputs show the pre-edge state).
    // ------------------------------------------------------------------
    typedef struct {
        logic        r, v;
        logic [3:0]  op;
        logic [15:0] res;
        logic        ov, st, fl, br, cc;
        logic [2:0]  ef;
        logic        eh;
        logic [7:0]  eo;
        logic [2:0]  fon, foff;
        logic        hoff;
    } vec_t;

    localparam int NV = 29;
    vec_t tbl [NV];

    function automatic vec_t mk(logic r, logic v, logic [3:0] op, logic [15:0] res,
                                logic ov, logic st, logic fl, logic br, logic cc,
                                logic [2:0] ef, logic eh, logic [7:0] eo,
                                logic [2:0] fon, logic [2:0] foff, logic hoff);
        vec_t t;
        t.r = r; t.v = v; t.op = op; t.res = res; t.ov = ov; t.st = st;
        t.fl = fl; t.br = br; t.cc = cc; t.ef = ef; t.eh = eh; t.eo = eo;
        t.fon = fon; t.foff = foff; t.hoff = hoff;
        return t;
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        m_z = 0; m_v = 0; m_n = 0; m_halt = 0; m_ovf = 0;

        //            r  v  op     res      ov st fl br cc  flags  h  ovf  fon    foff   hz
        tbl[0]  = mk(0, 0, 4'h0, 16'h0000, 0, 0, 0, 0, 1, 3'b000, 0, 0, 3'b000, 3'b000, 0); // reset state
        tbl[1]  = mk(0, 1, 4'h0, 16'h0000, 0, 0, 0, 0, 1, 3'b000, 0, 0, 3'b100, 3'b000, 0); // ADD 0
        tbl[2]  = mk(0, 1, 4'h1, 16'h8000, 1, 0, 0, 0, 1, 3'b100, 0, 0, 3'b011, 3'b100, 0); // SUB ovf
        tbl[3]  = mk(0, 1, 4'h2, 16'h0001, 0, 0, 0, 0, 1, 3'b011, 0, 1, 3'b011, 3'b011, 0); // XOR Z only
        tbl[4]  = mk(0, 0, 4'h0, 16'h0000, 0, 0, 0, 0, 1, 3'b011, 0, 1, 3'b011, 3'b011, 0);
        tbl[5]  = mk(0, 1, 4'h0, 16'h0000, 0, 1, 0, 0, 1, 3'b011, 0, 1, 3'b011, 3'b011, 0); // stalled
        tbl[6]  = mk(0, 1, 4'h0, 16'h0000, 0, 1, 0, 0, 1, 3'b011, 0, 1, 3'b011, 3'b011, 0); // stalled
        tbl[7]  = mk(0, 1, 4'h0, 16'h0000, 0, 0, 0, 0, 1, 3'b011, 0, 1, 3'b100, 3'b011, 0); // released
        tbl[8]  = mk(0, 0, 4'h0, 16'h0000, 0, 0, 0, 0, 1, 3'b100, 0, 1, 3'b100, 3'b100, 0);
        tbl[9]  = mk(0, 1, 4'h0, 16'h8000, 1, 1, 1, 1, 1, 3'b100, 0, 1, 3'b100, 3'b100, 0); // flush+stall
        tbl[10] = mk(0, 0, 4'h0, 16'h0000, 0, 0, 0, 0, 1, 3'b100, 0, 1, 3'b100, 3'b100, 0);
        tbl[11] = mk(0, 1, 4'h0, 16'h0005, 0, 0, 0, 1, 1, 3'b100, 0, 1, 3'b000, 3'b100, 1); // branch + ADD
        tbl[12] = mk(0, 1, 4'h0, 16'h0000, 0, 0, 0, 1, 1, 3'b000, 0, 1, 3'b100, 3'b000, 1); // branch + ADD 0
        tbl[13] = mk(0, 0, 4'h0, 16'h0000, 0, 0, 0, 1, 1, 3'b100, 0, 1, 3'b100, 3'b100, 0); // branch, EX empty
        tbl[14] = mk(0, 1, 4'h3, 16'h0000, 0, 0, 0, 1, 1, 3'b100, 0, 1, 3'b100, 3'b100, 0); // branch, non-producer
        tbl[15] = mk(0, 1, 4'h4, 16'h8000, 1, 0, 0, 0, 1, 3'b100, 0, 1, 3'b000, 3'b100, 0); // SLL
        tbl[16] = mk(0, 1, 4'h6, 16'h0000, 0, 0, 0, 0, 1, 3'b000, 0, 1, 3'b100, 3'b000, 0); // ROR
        tbl[17] = mk(0, 1, 4'h5, 16'h0001, 0, 0, 0, 0, 1, 3'b100, 0, 1, 3'b000, 3'b100, 0); // SRA
        tbl[18] = mk(0, 1, 4'h1, 16'hFFFF, 0, 0, 0, 0, 1, 3'b000, 0, 1, 3'b001, 3'b000, 0); // SUB neg
        tbl[19] = mk(0, 1, 4'hF, 16'h0000, 0, 1, 0, 0, 1, 3'b001, 0, 1, 3'b001, 3'b001, 0); // HLT stalled
        tbl[20] = mk(0, 1, 4'hF, 16'h0000, 0, 0, 0, 0, 1, 3'b001, 0, 1, 3'b001, 3'b001, 0); // HLT
        tbl[21] = mk(0, 1, 4'h0, 16'h0000, 1, 0, 0, 1, 1, 3'b001, 1, 1, 3'b001, 3'b001, 0); // ADD while halted
        tbl[22] = mk(0, 0, 4'h0, 16'h0000, 0, 0, 0, 0, 1, 3'b001, 1, 1, 3'b001, 3'b001, 0);
        tbl[23] = mk(1, 0, 4'h0, 16'h0000, 0, 0, 0, 0, 1, 3'b001, 1, 1, 3'b001, 3'b001, 0); // reset
        tbl[24] = mk(0, 0, 4'h0, 16'h0000, 0, 0, 0, 0, 1, 3'b000, 0, 0, 3'b000, 3'b000, 0);
        tbl[25] = mk(1, 1, 4'h0, 16'h0000, 1, 0, 0, 0, 0, 3'b000, 0, 0, 3'b000, 3'b000, 0); // reset beats commit
        tbl[26] = mk(0, 0, 4'h0, 16'h0000, 0, 0, 0, 0, 1, 3'b000, 0, 0, 3'b000, 3'b000, 0);
        tbl[27] = mk(0, 1, 4'h0, 16'h0000, 0, 1, 0, 1, 1, 3'b000, 0, 0, 3'b000, 3'b000, 1); // branch + stalled ADD
        tbl[28] = mk(0, 0, 4'h0, 16'h0000, 0, 0, 0, 0, 1, 3'b000, 0, 0, 3'b000, 3'b000, 0);

        drive(1, 0, 4'h0, 16'h0000, 0, 0, 0, 0);
        tick();
        tick();

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].r, tbl[i].v, tbl[i].op, tbl[i].res,
                  tbl[i].ov, tbl[i].st, tbl[i].fl, tbl[i].br);
            @(negedge clk);
            chk($sformatf("vec%0d.flags", i), {29'd0, flags}, {29'd0, tbl[i].ef});
            chk($sformatf("vec%0d.halted", i), {31'd0, halted}, {31'd0, tbl[i].eh});
            chk($sformatf("vec%0d.ovf_count", i), {24'd0, ovf_count}, {24'd0, tbl[i].eo});
            if (tbl[i].cc) begin
`ifdef FLAG_FWD_EN
                chk($sformatf("vec%0d.flags_fwd", i), {29'd0, flags_fwd}, {29'd0, tbl[i].fon});
                chk($sformatf("vec%0d.br_hazard", i), {31'd0, br_hazard}, 32'd0);
`else
                chk($sformatf("vec%0d.flags_fwd", i), {29'd0, flags_fwd}, {29'd0, tbl[i].foff});
                chk($sformatf("vec%0d.br_hazard", i), {31'd0, br_hazard}, {31'd0, tbl[i].hoff});
`endif
            end
            tick();
        end

        // Saturation: 300 back-to-back ADDs with overflow, count starts at 0
        for (int i = 0; i < 300; i++) begin
            drive(0, 1, 4'h0, 16'h0001, 1, 0, 0, 0);
            @(negedge clk);
            if (i == 254) chk("sat.ovf_254", {24'd0, ovf_count}, 32'd254);
            if (i == 255) chk("sat.ovf_255", {24'd0, ovf_count}, 32'd255);
            if (i == 299) chk("sat.ovf_hold", {24'd0, ovf_count}, 32'd255);
            tick();
        end
        drive(0, 0, 4'h0, 16'h0000, 0, 0, 0, 0);
        @(negedge clk);
        chk("sat.ovf_final", {24'd0, ovf_count}, 32'd255);
        chk("sat.flags", {29'd0, flags}, 32'b010);
        tick();

        // Randomized traffic against the model
        drive(1, 0, 4'h0, 16'h0000, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 600; i++) begin
            logic [3:0]  op;
            logic [15:0] res;
            op  = ($urandom_range(0, 63) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            res = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            drive($urandom_range(0, 79) == 0, $urandom_range(0, 7) != 0, op, res,
                  1'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0,
                  1'($urandom));
            @(negedge clk);
            chk($sformatf("rnd%0d.flags", i), {29'd0, flags}, {29'd0, m_flags()});
            chk($sformatf("rnd%0d.halted", i), {31'd0, halted}, {31'd0, m_halt});
            chk($sformatf("rnd%0d.ovf_count", i), {24'd0, ovf_count}, 32'(m_ovf));
            if (!rst) begin
                chk($sformatf("rnd%0d.flags_fwd", i), {29'd0, flags_fwd}, {29'd0, m_fwd()});
                chk($sformatf("rnd%0d.br_hazard", i), {31'd0, br_hazard}, {31'd0, m_haz()});
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
